e203_exu_adder_arb: RTL and testbench

Arbiter and sequencer for the shared wide adder inside the EXU ALU. It shares the adder between two requesters:
- the multiply/divide unit (MDV), which holds the adder for multi-cycle operations;
- the address-generation unit (AGU), which needs single-cycle operations.
It locks the adder to MDV for a whole operation, round-robins between the two when both are idle-contending, and carries a starvation guard for AGU.

---
 rtl/e203_exu_adder_arb.sv | 135 +++++++++++++
 tb/tb_e203_exu_adder_arb.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/e203_exu_adder_arb.sv
// Arbiter/sequencer for the EXU shared wide adder: MDV (multi-cycle, lockable) vs AGU (single-cycle).
// Optional perf counters are enabled by defining E203_ADDER_ARB_PERF_EN.
module e203_exu_adder_arb #(
  parameter int W         = 35,
  parameter int CW        = 3,
  parameter int STARVE_TH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_pulse,
  input  logic         mdv_req,
  input  logic         mdv_lock,
  output logic         mdv_gnt,
  input  logic [W-1:0] mdv_op1,
  input  logic [W-1:0] mdv_op2,
  input  logic         mdv_add,
  input  logic         mdv_sub,
  output logic [W-1:0] mdv_res,
  input  logic         agu_req,
  output logic         agu_gnt,
  input  logic [W-1:0] agu_op1,
  input  logic [W-1:0] agu_op2,
  output logic [W-1:0] agu_res,
  output logic [W-1:0] adder_op1,
  output logic [W-1:0] adder_op2,
  output logic         adder_add,
  output logic         adder_sub,
  input  logic [W-1:0] adder_res,
  output logic         agu_starve,
  output logic [31:0]  perf_mdv_cyc,
  output logic [31:0]  perf_agu_stall
);

  typedef enum logic {ST_IDLE = 1'b0, ST_MDV = 1'b1} st_e;

  localparam logic [31:0] TH = 32'(STARVE_TH);

  st_e           r_st;
  st_e           w_st_nxt;
  logic          r_last_mdv;
  logic [CW-1:0] r_wait_cnt;
  logic          w_mdv_gnt;
  logic          w_agu_gnt;
  logic          w_agu_stall;

  assign agu_starve  = (32'(r_wait_cnt) >= TH);
  assign w_agu_stall = agu_req & ~w_agu_gnt;

  // Grant and next-state decode; flush only steers the next state, never this cycle's grant.
  always_comb begin
    w_mdv_gnt = 1'b0;
    w_agu_gnt = 1'b0;
    w_st_nxt  = r_st;
    if (rst_n) begin
      case (r_st)
        ST_IDLE: begin
          if (mdv_req && agu_req) begin
            if (agu_starve || r_last_mdv) w_agu_gnt = 1'b1;
            else                          w_mdv_gnt = 1'b1;
          end else begin
            w_mdv_gnt = mdv_req;
            w_agu_gnt = agu_req;
          end
          if (w_mdv_gnt && mdv_lock) w_st_nxt = ST_MDV;
        end
        ST_MDV: begin
          w_mdv_gnt = mdv_req;
          if (!(mdv_req && mdv_lock)) w_st_nxt = ST_IDLE;
        end
        default: w_st_nxt = ST_IDLE;
      endcase
      if (flush_pulse) w_st_nxt = ST_IDLE;
    end
  end

  assign mdv_gnt = w_mdv_gnt;
  assign agu_gnt = w_agu_gnt;

  // Operands are gated to zero when nobody owns the adder.
  always_comb begin
    adder_op1 = '0;
    adder_op2 = '0;
    adder_add = 1'b0;
    adder_sub = 1'b0;
    if (w_mdv_gnt) begin
      adder_op1 = mdv_op1;
      adder_op2 = mdv_op2;
      adder_add = mdv_add;
      adder_sub = mdv_sub;
    end else if (w_agu_gnt) begin
      adder_op1 = agu_op1;
      adder_op2 = agu_op2;
      adder_add = 1'b1;
    end
  end

  assign mdv_res = adder_res;
  assign agu_res = adder_res;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_st       <= ST_IDLE;
      r_last_mdv <= 1'b0;
      r_wait_cnt <= '0;
    end else begin
      r_st <= w_st_nxt;
      if (w_mdv_gnt)      r_last_mdv <= 1'b1;
      else if (w_agu_gnt) r_last_mdv <= 1'b0;
      if (!w_agu_stall)       r_wait_cnt <= '0;
      else if (~&r_wait_cnt)  r_wait_cnt <= r_wait_cnt + 1'b1;
    end
  end

`ifdef E203_ADDER_ARB_PERF_EN
  logic [31:0] r_perf_mdv_cyc;
  logic [31:0] r_perf_agu_stall;

  always_ff @(posedge clk) begin
    if (!rst_n || flush_pulse) begin
      r_perf_mdv_cyc   <= '0;
      r_perf_agu_stall <= '0;
    end else begin
      if (w_mdv_gnt)   r_perf_mdv_cyc   <= r_perf_mdv_cyc + 32'd1;
      if (w_agu_stall) r_perf_agu_stall <= r_perf_agu_stall + 32'd1;
    end
  end

  assign perf_mdv_cyc   = r_perf_mdv_cyc;
  assign perf_agu_stall = r_perf_agu_stall;
`else
  assign perf_mdv_cyc   = '0;
  assign perf_agu_stall = '0;
`endif

endmodule

// File: tb/tb_e203_exu_adder_arb.sv
// Bench for e203_exu_adder_arb: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a behavioural ownership model.
module tb_e203_exu_adder_arb;
  localparam int W = 35;
  localparam int TH = 4;
  localparam int WMAX = 7;

  logic         clk = 1'b0;
  logic         rst_n, flush_pulse;
  logic         mdv_req, mdv_lock, mdv_add, mdv_sub, agu_req;
  logic [W-1:0] mdv_op1, mdv_op2, agu_op1, agu_op2;
  logic         mdv_gnt, agu_gnt, adder_add, adder_sub, agu_starve;
  logic [W-1:0] mdv_res, agu_res, adder_op1, adder_op2, adder_res;
  logic [31:0]  perf_mdv_cyc, perf_agu_stall;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  function automatic logic [W-1:0] fadd(logic [W-1:0] a, logic [W-1:0] b, logic ad, logic sb);
    if (sb)      return a - b;
    else if (ad) return a + b;
    else         return '0;
  endfunction

  assign adder_res = fadd(adder_op1, adder_op2, adder_add, adder_sub);

  e203_exu_adder_arb #(.W(W), .CW(3), .STARVE_TH(TH)) dut (
    .clk(clk), .rst_n(rst_n), .flush_pulse(flush_pulse),
    .mdv_req(mdv_req), .mdv_lock(mdv_lock), .mdv_gnt(mdv_gnt),
    .mdv_op1(mdv_op1), .mdv_op2(mdv_op2), .mdv_add(mdv_add), .mdv_sub(mdv_sub),
    .mdv_res(mdv_res), .agu_req(agu_req), .agu_gnt(agu_gnt),
    .agu_op1(agu_op1), .agu_op2(agu_op2), .agu_res(agu_res),
    .adder_op1(adder_op1), .adder_op2(adder_op2), .adder_add(adder_add),
    .adder_sub(adder_sub), .adder_res(adder_res), .agu_starve(agu_starve),
    .perf_mdv_cyc(perf_mdv_cyc), .perf_agu_stall(perf_agu_stall)
  );

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: who holds the adder, who won last, how long AGU has waited.
  bit           m_locked = 0;
  bit           m_last_mdv = 0;
  int           m_wait = 0;
  logic [31:0]  m_pmdv = 0, m_pstall = 0;
  bit           e_m, e_a;
  logic [W-1:0] e_op1, e_op2;
  bit           e_add, e_sub;

  always @(negedge clk) begin
    if (chk_en) begin
      e_m = 0; e_a = 0;
      if (rst_n) begin
        if (m_locked)                  e_m = mdv_req;
        else if (mdv_req && agu_req) begin
          e_a = (m_wait >= TH) || m_last_mdv;
          e_m = !e_a;
        end else begin
          e_m = mdv_req; e_a = agu_req;
        end
      end
      e_op1 = e_m ? mdv_op1 : e_a ? agu_op1 : '0;
      e_op2 = e_m ? mdv_op2 : e_a ? agu_op2 : '0;
      e_add = e_m ? mdv_add : e_a;
      e_sub = e_m ? mdv_sub : 1'b0;
      chk("mdv_gnt", 64'(mdv_gnt), 64'(e_m));
      chk("agu_gnt", 64'(agu_gnt), 64'(e_a));
      chk("adder_op1", 64'(adder_op1), 64'(e_op1));
      chk("adder_op2", 64'(adder_op2), 64'(e_op2));
      chk("adder_add", 64'(adder_add), 64'(e_add));
      chk("adder_sub", 64'(adder_sub), 64'(e_sub));
      chk("mdv_res", 64'(mdv_res), 64'(fadd(e_op1, e_op2, e_add, e_sub)));
      chk("agu_res", 64'(agu_res), 64'(fadd(e_op1, e_op2, e_add, e_sub)));
      chk("agu_starve", 64'(agu_starve), 64'(m_wait >= TH));
`ifdef E203_ADDER_ARB_PERF_EN
      chk("perf_mdv_cyc", 64'(perf_mdv_cyc), 64'(m_pmdv));
      chk("perf_agu_stall", 64'(perf_agu_stall), 64'(m_pstall));
`else
      chk("perf_mdv_cyc", 64'(perf_mdv_cyc), 64'd0);
      chk("perf_agu_stall", 64'(perf_agu_stall), 64'd0);
`endif
      // state seen after the coming clock edge
      if (!rst_n) begin
        m_locked = 0; m_last_mdv = 0; m_wait = 0; m_pmdv = 0; m_pstall = 0;
      end else begin
        m_locked = !flush_pulse && e_m && mdv_lock;
        if (e_m)      m_last_mdv = 1;
        else if (e_a) m_last_mdv = 0;
        if (agu_req && !e_a) m_wait = (m_wait < WMAX) ? m_wait + 1 : WMAX;
        else                 m_wait = 0;
        if (flush_pulse) begin
          m_pmdv = 0; m_pstall = 0;
        end else begin
          if (e_m)             m_pmdv++;
          if (agu_req && !e_a) m_pstall++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic setin(bit mr, bit ml, bit ar, bit fl);
    mdv_req = mr; mdv_lock = ml; agu_req = ar; flush_pulse = fl;
  endtask

  task automatic sample();
    @(negedge clk); #1;
  endtask

  initial begin
    rst_n = 0; flush_pulse = 0;
    mdv_req = 1; mdv_lock = 1; agu_req = 1; mdv_add = 1; mdv_sub = 0;
    mdv_op1 = 35'h1; mdv_op2 = 35'h2; agu_op1 = 35'h3; agu_op2 = 35'h4;
    @(posedge clk); #1 chk_en = 1;
    // 1. reset, requests held: nothing granted, adder gated
    sample();
    chk("rst_mdv_gnt", 64'(mdv_gnt), 64'd0);
    chk("rst_agu_gnt", 64'(agu_gnt), 64'd0);
    chk("rst_adder_op1", 64'(adder_op1), 64'd0);
    tick(); rst_n = 1; setin(0, 0, 0, 0);
    sample();
    chk("idle_mdv_gnt", 64'(mdv_gnt), 64'd0);
    chk("idle_agu_gnt", 64'(agu_gnt), 64'd0);
    chk("idle_adder_op1", 64'(adder_op1), 64'd0);
    chk("idle_starve", 64'(agu_starve), 64'd0);
    // 2. lone AGU request, same-cycle result
    tick(); setin(0, 0, 1, 0); agu_op1 = 35'h10; agu_op2 = 35'h05;
    sample();
    chk("agu_only_gnt", 64'(agu_gnt), 64'd1);
    chk("agu_only_add", 64'(adder_add), 64'd1);
    chk("agu_only_res", 64'(agu_res), 64'h15);
    // 3. both request with last=AGU: MDV locks for 4 cycles, AGU next
    for (int c = 0; c < 4; c++) begin
      tick(); setin(1, c < 3, 1, 0);
      sample();
      chk("lock_mdv_gnt", 64'(mdv_gnt), 64'd1);
      chk("lock_agu_gnt", 64'(agu_gnt), 64'd0);
    end
    tick(); setin(0, 0, 1, 0);
    sample();
    chk("post_lock_agu_gnt", 64'(agu_gnt), 64'd1);
    chk("post_lock_starve", 64'(agu_starve), 64'd1);
    // 4. AGU waits 5 cycles under a lock, then wins in idle; starve clears
    for (int c = 0; c < 5; c++) begin
      tick(); setin(1, c < 4, 1, 0);
      sample();
      chk("starve_phase", 64'(agu_starve), 64'(c >= 4));
    end
    tick(); setin(1, 1, 1, 0);
    sample();
    chk("starve_agu_wins", 64'(agu_gnt), 64'd1);
    chk("starve_mdv_lost", 64'(mdv_gnt), 64'd0);
    chk("starve_flag", 64'(agu_starve), 64'd1);
    tick(); setin(0, 0, 0, 0);
    sample();
    chk("starve_cleared", 64'(agu_starve), 64'd0);
    // 5. flush on the 2nd cycle of a locked op
    tick(); setin(1, 1, 0, 0);
    sample();
    chk("fl_c0_mdv", 64'(mdv_gnt), 64'd1);
    tick(); setin(1, 1, 1, 1);
    sample();
    chk("fl_c1_mdv", 64'(mdv_gnt), 64'd1);
    tick(); setin(1, 1, 1, 0);
    sample();
    chk("fl_c2_agu", 64'(agu_gnt), 64'd1);
    chk("fl_c2_mdv", 64'(mdv_gnt), 64'd0);
    // 6. perf: clear with a flush, 4-cycle MDV op with AGU waiting
    tick(); setin(0, 0, 0, 1);
    for (int c = 0; c < 4; c++) begin
      tick(); setin(1, c < 3, 1, 0);
    end
    tick(); setin(0, 0, 0, 0);
    sample();
`ifdef E203_ADDER_ARB_PERF_EN
    chk("perf_mdv_4", 64'(perf_mdv_cyc), 64'd4);
    chk("perf_stall_4", 64'(perf_agu_stall), 64'd4);
`else
    chk("perf_mdv_off", 64'(perf_mdv_cyc), 64'd0);
    chk("perf_stall_off", 64'(perf_agu_stall), 64'd0);
`endif
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      tick();
      rst_n       = ($urandom_range(0, 63) != 0);
      flush_pulse = ($urandom_range(0, 15) == 0);
      mdv_req     = ($urandom_range(0, 99) < 60);
      mdv_lock    = ($urandom_range(0, 99) < 70);
      agu_req     = ($urandom_range(0, 99) < 50);
      mdv_add     = 1'($urandom);
      mdv_sub     = 1'($urandom);
      mdv_op1     = W'({$urandom, $urandom});
      mdv_op2     = W'({$urandom, $urandom});
      agu_op1     = W'({$urandom, $urandom});
      agu_op2     = W'({$urandom, $urandom});
    end
    tick();
    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
